// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard unit: forward selects, halt FSM
// states, the halt opcode and the branch-counter reset value.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } halt_state_e;

  localparam logic [6:0] HALT_OPCODE = 7'b0000000;
  localparam logic [1:0] BHT_RESET   = 2'b01;

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic fwd_sel_e fwd_select(input logic       mem_we,
                                          input logic [4:0] mem_rd,
                                          input logic       wb_we,
                                          input logic [4:0] wb_rd,
                                          input logic [4:0] rs);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return FWD_EXMEM;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))    return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard unit (slave).
interface pipe_hazard_unit_if
  import pipe_pkg::*;
#(
  parameter int PC_W = 32
);
  logic            id_valid, id_halt;
  logic [4:0]      id_rs1, id_rs2;
  logic [4:0]      ex_rd, mem_rd, wb_rd;
  logic            ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load;
  logic            ex_is_branch, ex_taken, ex_pred;
  logic [PC_W-1:0] ex_pc, ex_target, if_pc;
  fwd_sel_e        fwd_a, fwd_b;
  logic            stall, flush;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            predict_taken;
  logic            fetch_hold, halted;

  modport master (
    output id_valid, id_halt, id_rs1, id_rs2, ex_rd, mem_rd, wb_rd,
           ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load,
           ex_is_branch, ex_taken, ex_pred, ex_pc, ex_target, if_pc,
    input  fwd_a, fwd_b, stall, flush, redirect_valid, redirect_pc,
           predict_taken, fetch_hold, halted
  );

  modport slave (
    input  id_valid, id_halt, id_rs1, id_rs2, ex_rd, mem_rd, wb_rd,
           ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load,
           ex_is_branch, ex_taken, ex_pred, ex_pc, ex_target, if_pc,
    output fwd_a, fwd_b, stall, flush, redirect_valid, redirect_pc,
           predict_taken, fetch_hold, halted
  );
endinterface

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating branch counters; asynchronous read returns the
// value before any same-cycle update.
module bht_2bit
  import pipe_pkg::*;
#(
  parameter int BHT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(BHT_DEPTH)-1:0] i_rd_idx,
  output logic                         o_rd_taken,
  input  logic                         i_upd_en,
  input  logic [$clog2(BHT_DEPTH)-1:0] i_upd_idx,
  input  logic                         i_upd_taken
);

  logic [1:0] r_cnt [BHT_DEPTH];

  assign o_rd_taken = r_cnt[i_rd_idx][1];

  // NOTE: this table is small and must start weakly-not-taken, so it is a
  // reset flop array rather than a RAM; sequential state uses <= only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_cnt[i] <= BHT_RESET;
    end else if (i_upd_en) begin
      if (i_upd_taken) begin
        if (r_cnt[i_upd_idx] != 2'b11) r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] + 2'd1;
      end else if (r_cnt[i_upd_idx] != 2'b00) begin
        r_cnt[i_upd_idx] <= r_cnt[i_upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// In-order pipeline hazard unit: operand forwarding, load-use stall,
// mispredict flush/redirect, branch prediction and halt draining.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int LOAD_LAT  = 1,
  parameter int DRAIN_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_unit_if.slave  hz
);

  localparam int              IDX_W   = $clog2(BHT_DEPTH);
  localparam int              DRN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [2:0]       r_stall_cnt;
  halt_state_e      r_state;
  logic [DRN_W-1:0] r_drain_cnt;
  logic             r_halted;
  logic             w_hazard, w_flush, w_stall;
  logic [XLEN-1:0]  w_unused_xlen;
  logic             w_unused_if_pc;

  assign w_unused_xlen  = '0;
  assign w_unused_if_pc = ^{hz.if_pc[PC_W-1:IDX_W+2], hz.if_pc[1:0]};

  assign hz.fwd_a = fwd_select(hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd, hz.id_rs1);
  assign hz.fwd_b = fwd_select(hz.mem_regwrite, hz.mem_rd, hz.wb_regwrite, hz.wb_rd, hz.id_rs2);

  assign w_hazard = hz.id_valid && hz.ex_is_load && hz.ex_regwrite && (hz.ex_rd != 5'd0)
                    && ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));
  assign w_flush  = hz.ex_is_branch && (hz.ex_taken != hz.ex_pred);
  // A mispredict squashes the stalled instruction, so flush masks stall.
  assign w_stall  = !w_flush && ((r_stall_cnt != 3'd0) || w_hazard);

  assign hz.stall          = w_stall;
  assign hz.flush          = w_flush;
  assign hz.redirect_valid = w_flush;
  assign hz.redirect_pc    = hz.ex_taken ? hz.ex_target : hz.ex_pc + PC_STEP;
  assign hz.halted         = r_halted;
  assign hz.fetch_hold     = w_stall || ((r_state != ST_RUN) && !((r_state == ST_DRAIN) && w_flush));

  // The hazard cycle itself is the first stall cycle; the counter covers the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 3'd0;
    end else if (w_flush) begin
      r_stall_cnt <= 3'd0;
    end else if (r_stall_cnt != 3'd0) begin
      r_stall_cnt <= r_stall_cnt - 3'd1;
    end else if (w_hazard) begin
      r_stall_cnt <= 3'(LOAD_LAT - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (hz.id_valid && hz.id_halt && !w_stall && !w_flush) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRN_W'(DRAIN_CYC - 1);
          end
        end
        ST_DRAIN: begin
          if (w_flush) begin
            r_state <= ST_RUN;
          end else if (r_drain_cnt == '0) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - DRN_W'(1);
          end
        end
        ST_HALTED: r_halted <= 1'b1;
        default:   r_state  <= ST_RUN;
      endcase
    end
  end

  bht_2bit #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (hz.if_pc[IDX_W+1:2]),
    .o_rd_taken  (hz.predict_taken),
    .i_upd_en    (hz.ex_is_branch),
    .i_upd_idx   (hz.ex_pc[IDX_W+1:2]),
    .i_upd_taken (hz.ex_taken)
  );

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (redirect arithmetic uses PC_W only).
REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
REQ-003 SHALL have parameter BHT_DEPTH, default 16, power of two ≥2, number of 2-bit branch counters.
REQ-004 SHALL have parameter LOAD_LAT, default 1, range 1..7, load-use stall cycles.
REQ-005 SHALL have parameter DRAIN_CYC, default 3, cycles from halt leaving ID to halt retiring.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 id_valid, id_halt  input  1 each  ID holds valid instruction; it is the halt opcode (7'b0000000).
REQ-009 id_rs1, id_rs2  input  5 each  ID source registers.
REQ-010 ex_rd, mem_rd, wb_rd  input  5 each  destination registers in EX, EX/MEM, MEM/WB.
REQ-011 ex_regwrite, mem_regwrite, wb_regwrite, ex_is_load  input  1 each  stage write-enable / load flags.
REQ-012 ex_is_branch, ex_taken, ex_pred  input  1 each  EX holds branch; resolved outcome; prediction it carried.
REQ-013 ex_pc, ex_target, if_pc  input  PC_W each  EX branch PC, taken target, current fetch PC.
REQ-014 fwd_a, fwd_b  output  2 each  operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB write data.
REQ-015 stall, flush  output  1 each  hold IF/ID and bubble ID/EX; squash IF/ID and ID/EX.
REQ-016 redirect_valid, redirect_pc  output  1, PC_W  fetch redirect request and address.
REQ-017 predict_taken  output  1  prediction for if_pc.
REQ-018 fetch_hold, halted  output  1 each  freeze PC; halt retired.

Function
REQ-019 fwd_a SHALL be 01 when mem_regwrite, mem_rd≠0, mem_rd==id_rs1; else 10 when wb_regwrite, wb_rd≠0, wb_rd==id_rs1; else 00 (combinational, EX/MEM priority); fwd_b identical on id_rs2.
REQ-020 Load-use hazard = id_valid & ex_is_load & ex_regwrite & ex_rd≠0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-021 On hazard with counter idle, stall SHALL assert combinationally that cycle and remain high exactly LOAD_LAT consecutive cycles via a 3-bit down-counter; new hazards ignored while counter non-zero.
REQ-022 flush = ex_is_branch & (ex_taken ≠ ex_pred), combinational; redirect_valid = flush.
REQ-023 redirect_pc SHALL be ex_target when ex_taken, else ex_pc+4 modulo 2^PC_W.
REQ-024 flush SHALL dominate stall: stall forced low and stall counter cleared same cycle.
REQ-025 BHT index = pc[log2(BHT_DEPTH)+1:2]; predict_taken = counter[if_pc index] bit 1.
REQ-026 On ex_is_branch, counter[ex_pc index] SHALL increment if ex_taken else decrement, saturating at 3/0, at next edge.
REQ-027 Same-index read and update in one cycle SHALL return the pre-update value.
REQ-028 Halt FSM states RUN, DRAIN, HALTED; RUN→DRAIN when id_valid & id_halt & !stall & !flush.
REQ-029 DRAIN SHALL count DRAIN_CYC cycles then enter HALTED; flush during DRAIN SHALL return to RUN (halt was wrong-path).
REQ-030 HALTED SHALL be sticky until rst; halted=1 only in HALTED.
REQ-031 fetch_hold = stall | (state≠RUN); flush in DRAIN clears fetch_hold same cycle.

Reset
REQ-032 rst SHALL force state RUN, stall counter 0, all BHT counters 2'b01, halted 0; combinational outputs follow inputs.
REQ-033 rst asserted mid-stall or mid-drain SHALL abort immediately; first post-reset cycle behaves as from power-up.

Structure
REQ-034 Forward-select encodings, FSM state encoding, HALT opcode and counter reset value SHALL live in shared package pipe_pkg.
REQ-035 BHT SHALL be sub-module bht_2bit (parameter BHT_DEPTH; ports read index, update enable/index/taken).

Verification
REQ-036 mem_rd=wb_rd=id_rs1=5, both regwrite -> fwd_a=01; mem_regwrite=0 -> 10; all rd=0 -> 00.
REQ-037 LOAD_LAT=2, ex_is_load, ex_rd=7=id_rs2 -> stall high exactly 2 cycles, fwd_b unaffected.
REQ-038 ex_pc=0x100, taken, pred 0, target 0x200 -> flush=1, redirect_pc=0x200; not-taken, pred 1 -> 0x104.
REQ-039 Three taken updates at pc 0x40 from reset -> predict_taken for if_pc=0x40 goes 0,1,1; counter saturates at 3.
REQ-040 id_halt accepted -> fetch_hold next cycle, halted after DRAIN_CYC cycles; repeat with flush in DRAIN -> RUN, halted stays 0.
REQ-041 rst pulse during active stall and during DRAIN -> stall=0, halted=0, BHT predicts not-taken everywhere.
